// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM-bus arbiter.
//   state_e   : arbiter FSM states (IDLE, REQ, WAIT)
//   OWN_I/D   : owner of the in-flight bus transaction
//   SIZE_WORD : bus_size encoding for a 32-bit word access
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic       OWN_I     = 1'b0;
  localparam logic       OWN_D     = 1'b1;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus (req / addr_ok / data_ok) between the core's
// instruction-fetch port and data port. Accesses are serialised with data
// first, returned data is held until overwritten, and the stall outputs
// freeze the pipeline until every enabled port of the current step is done.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   i_en, i_addr                  fetch request for the current step
//   i_rdata, i_stall              fetched word (held); fetch stall
//   d_en, d_wen, d_addr, d_wdata  data request (d_wen = 0 means read)
//   d_rdata, d_stall              load data (held); data stall
//   bus_req .. bus_wdata          request side of the shared bus
//   bus_addr_ok, bus_data_ok,
//   bus_rdata                     response side of the shared bus
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_en,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e            state_q, state_d;
  logic              owner_q;
  logic              i_done_q, d_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic i_pend, d_pend, any_pend, step_adv;
  logic latch_i, latch_d, complete;

  // Per-port outstanding work; these drive issue decisions.
  assign i_pend   = i_en & ~i_done_q;
  assign d_pend   = d_en & ~d_done_q;
  assign any_pend = i_pend | d_pend;

  // An enabled port keeps stalling while anything in the step is still
  // outstanding, so both stalls fall in the same cycle; a disabled port
  // never stalls.
  assign i_stall  = i_en & any_pend;
  assign d_stall  = d_en & any_pend;
  assign step_adv = ~any_pend;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    latch_i  = 1'b0;
    latch_d  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend) begin
          latch_d = 1'b1;
          state_d = REQ;
        end else if (i_pend) begin
          latch_i = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_addr_ok && bus_data_ok) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (bus_addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every register here, including the returned-data holders, is
  // cleared by reset; an abandoned transaction must leave nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_I;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (latch_d) begin
        owner_q <= OWN_D;
        addr_q  <= d_addr;
        wstrb_q <= d_wen;
        wdata_q <= d_wdata;
      end else if (latch_i) begin
        owner_q <= OWN_I;
        addr_q  <= i_addr;
        wstrb_q <= '0;
      end

      // A completion can only coincide with a step advance if the core
      // dropped en mid-transfer; that result belongs to an abandoned step,
      // so clearing wins and the next step starts clean.
      if (step_adv) begin
        i_done_q <= 1'b0;
        d_done_q <= 1'b0;
      end else if (complete) begin
        if (owner_q == OWN_D) d_done_q <= 1'b1;
        else                  i_done_q <= 1'b1;
      end

      if (complete) begin
        if (owner_q == OWN_I)    i_rdata_q <= bus_rdata;
        else if (wstrb_q == '0)  d_rdata_q <= bus_rdata;
      end
    end
  end

  // Bus fields come only from the latched request, so the core may change
  // its inputs freely while the slave is still deciding.
  assign bus_req   = (state_q == REQ);
  assign bus_wr    = |wstrb_q;
  assign bus_size  = SIZE_WORD;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: a directed vector table, a
// reset-during-WAIT sequence and randomised steps, with a bus-slave model
// whose handshake delays are set per step.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, d_en;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wen;
  logic [31:0] i_rdata, d_rdata;
  logic        i_stall, d_stall;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_en(d_en), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bus slave model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t        mon_q[$];
  logic [31:0] rsp_q[$];
  int          sa = 0;   // cycles addr_ok is withheld
  int          sb = 0;   // extra cycles after addr_ok before data_ok
  int          sp = 0;   // 0 idle, 1 request pending, 2 awaiting data
  int          scnt = 0;
  txn_t        cur;

  task automatic give_data();
    bus_data_ok = 1'b1;
    if (rsp_q.size() > 0) bus_rdata = rsp_q.pop_front();
    else                  bus_rdata = $urandom;
  endtask

  initial begin
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    forever begin
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;   // junk unless data_ok is high
      if (!rst) begin
        sp = 0;
      end else begin
        if (sp == 0 && bus_req) begin
          cur.addr  = bus_addr;
          cur.wr    = bus_wr;
          cur.wstrb = bus_wstrb;
          cur.wdata = bus_wdata;
          mon_q.push_back(cur);
          sp   = 1;
          scnt = 0;
        end
        if (sp == 1) begin
          check("req_held", {63'd0, bus_req}, 64'd1);
          check("addr_stable", {32'd0, bus_addr}, {32'd0, cur.addr});
          check("size_word", {62'd0, bus_size}, 64'd2);
          if (scnt == sa) begin
            bus_addr_ok = 1'b1;
            if (sb == 0) begin
              give_data();
              sp = 0;
            end else begin
              sp   = 2;
              scnt = 0;
            end
          end else begin
            scnt++;
          end
        end else if (sp == 2) begin
          check("req_low_in_wait", {63'd0, bus_req}, 64'd0);
          scnt++;
          if (scnt == sb) begin
            give_data();
            sp = 0;
          end
        end else if (!bus_req && $urandom_range(3) == 0) begin
          bus_data_ok = 1'b1;   // stray response while idle: must be ignored
        end
      end
    end
  end

  // ---------------- one pipeline step ----------------
  // Called at a falling edge (or just after one). Cycle counts are falling
  // edges after the inputs were applied; each access costs 2 + a + b.
  task automatic run_step(
    input logic ie, input logic [31:0] ia,
    input logic de, input logic [3:0] dwen, input logic [31:0] da, input logic [31:0] dwd,
    input int a, input int b, input logic [31:0] rd, input logic [31:0] ri,
    input int exp_cyc, input logic [31:0] exp_ir, input logic [31:0] exp_dr,
    input logic scramble);
    txn_t exp_q[$];
    txn_t t;
    int   i_low, d_low, cyc;
    sa = a;
    sb = b;
    mon_q.delete();
    rsp_q.delete();
    if (de) rsp_q.push_back(rd);
    if (ie) rsp_q.push_back(ri);
    i_en = ie; i_addr = ia;
    d_en = de; d_wen = dwen; d_addr = da; d_wdata = dwd;
    #1;
    check("i_stall_at_apply", {63'd0, i_stall}, {63'd0, ie});
    check("d_stall_at_apply", {63'd0, d_stall}, {63'd0, de});
    i_low = i_stall ? -1 : 0;
    d_low = d_stall ? -1 : 0;
    cyc = 0;
    while ((i_low < 0 || d_low < 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (i_low < 0 && !i_stall) i_low = cyc;
      if (d_low < 0 && !d_stall) d_low = cyc;
      if (scramble && de) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wen   = 4'($urandom);
      end
    end
    check("i_stall_drop_cycle", 64'(i_low), ie ? 64'(exp_cyc) : 64'd0);
    check("d_stall_drop_cycle", 64'(d_low), de ? 64'(exp_cyc) : 64'd0);
    i_en = 1'b0;
    d_en = 1'b0;
    check("i_rdata", {32'd0, i_rdata}, {32'd0, exp_ir});
    check("d_rdata", {32'd0, d_rdata}, {32'd0, exp_dr});
    if (de) begin
      t.addr = da; t.wr = |dwen; t.wstrb = dwen; t.wdata = dwd;
      exp_q.push_back(t);
    end
    if (ie) begin
      t.addr = ia; t.wr = 1'b0; t.wstrb = 4'd0; t.wdata = '0;
      exp_q.push_back(t);
    end
    check("txn_count", 64'(mon_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) begin
      check("txn_addr", {32'd0, mon_q[k].addr}, {32'd0, exp_q[k].addr});
      check("txn_wr", {63'd0, mon_q[k].wr}, {63'd0, exp_q[k].wr});
      check("txn_wstrb", {60'd0, mon_q[k].wstrb}, {60'd0, exp_q[k].wstrb});
      if (exp_q[k].wr)
        check("txn_wdata", {32'd0, mon_q[k].wdata}, {32'd0, exp_q[k].wdata});
    end
    @(negedge clk);   // step-advance edge passes here
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        ie;
    logic [31:0] ia;
    logic        de;
    logic [3:0]  dwen;
    logic [31:0] da;
    logic [31:0] dwd;
    int          a;
    int          b;
    logic [31:0] rd;
    logic [31:0] ri;
    int          cyc;
    logic [31:0] exp_ir;
    logic [31:0] exp_dr;
    logic        scr;
  } vec_t;

  vec_t vecs[7];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_req"},   {63'd0, bus_req},   64'd0);
    check({tag, "_bus_wr"},    {63'd0, bus_wr},    64'd0);
    check({tag, "_bus_wstrb"}, {60'd0, bus_wstrb}, 64'd0);
    check({tag, "_bus_addr"},  {32'd0, bus_addr},  64'd0);
    check({tag, "_bus_wdata"}, {32'd0, bus_wdata}, 64'd0);
    check({tag, "_i_rdata"},   {32'd0, i_rdata},   64'd0);
    check({tag, "_d_rdata"},   {32'd0, d_rdata},   64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] m_ir, m_dr;

  initial begin
    //           ie  ia            de dwen     da            dwd           a  b  rd            ri            cyc exp_ir        exp_dr        scr
    vecs[0] = '{1'b1, 32'hBFC00000, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h3C080001, 2,  32'h3C080001, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 32'hBFC00004, 1'b1, 4'b0000, 32'h80000010, 32'h0,        0, 0, 32'hDEADBEEF, 32'h24020005, 4,  32'h24020005, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 4'b0011, 32'h80000020, 32'h0000ABCD, 0, 0, 32'h55AA55AA, 32'h0,        2,  32'h24020005, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b0, 32'h0,        1'b1, 4'b0000, 32'h80000030, 32'h0,        3, 0, 32'hCAFEF00D, 32'h0,        5,  32'h24020005, 32'hCAFEF00D, 1'b1};
    vecs[4] = '{1'b1, 32'hBFC00008, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 3, 32'h0,        32'h12345678, 5,  32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        0,  32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b1, 32'hBFC0000C, 1'b1, 4'b1111, 32'h80000040, 32'h01020304, 1, 2, 32'h77777777, 32'h0BADC0DE, 10, 32'h0BADC0DE, 32'hCAFEF00D, 1'b1};

    i_en = 1'b0; i_addr = '0;
    d_en = 1'b0; d_wen = '0; d_addr = '0; d_wdata = '0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    check("reset_i_stall", {63'd0, i_stall}, 64'd0);
    check("reset_d_stall", {63'd0, d_stall}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      run_step(vecs[v].ie, vecs[v].ia, vecs[v].de, vecs[v].dwen, vecs[v].da, vecs[v].dwd,
               vecs[v].a, vecs[v].b, vecs[v].rd, vecs[v].ri, vecs[v].cyc,
               vecs[v].exp_ir, vecs[v].exp_dr, vecs[v].scr);

    // Reset while the fetch is waiting for data_ok; the fetch then re-issues.
    sa = 0;
    sb = 20;
    rsp_q.delete();
    i_en = 1'b1;
    i_addr = 32'hBFC00010;
    repeat (4) @(negedge clk);
    check("wait_before_reset_i_stall", {63'd0, i_stall}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    check("async_reset_i_stall", {63'd0, i_stall}, 64'd1);
    repeat (2) @(negedge clk);
    check("held_reset_bus_req", {63'd0, bus_req}, 64'd0);
    #2 rst = 1'b1;
    run_step(1'b1, 32'hBFC00010, 1'b0, 4'd0, 32'h0, 32'h0, 0, 0, 32'h0, 32'hAABBCCDD,
             2, 32'hAABBCCDD, 32'h0, 1'b0);
    m_ir = 32'hAABBCCDD;
    m_dr = 32'h0;

    // Randomised steps against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic        ie, de;
      logic [3:0]  dwen;
      logic [31:0] ia, da, dwd, rd, ri, e_ir, e_dr;
      int          a, b, cyc;
      ie   = 1'($urandom_range(1));
      de   = 1'($urandom_range(1));
      ia   = {$urandom, 2'b00} ;
      da   = {$urandom, 2'b00};
      dwd  = $urandom;
      dwen = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      a    = $urandom_range(0, 3);
      b    = $urandom_range(0, 3);
      rd   = $urandom;
      ri   = $urandom;
      cyc  = (int'(ie) + int'(de)) * (2 + a + b);
      e_ir = ie ? ri : m_ir;
      e_dr = (de && dwen == 4'd0) ? rd : m_dr;
      run_step(ie, ia, de, dwen, da, dwd, a, b, rd, ri, cyc, e_ir, e_dr, 1'b1);
      m_ir = e_ir;
      m_dr = e_dr;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
